// File: rtl/sniffer_pkg.sv
// Shared definitions for the data sniffer blocks.
// Holds the ASCII constants used for byte classification, the state
// encoding of the shift controller and the digit/whitespace helpers.
package sniffer_pkg;

  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam logic [7:0] ASCII_9   = 8'h39;
  localparam logic [7:0] ASCII_SP  = 8'h20;
  localparam logic [7:0] ASCII_TAB = 8'h09;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_CR  = 8'h0D;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // True for the decimal digits '0'..'9'.
  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

  // True for space, tab, line feed and carriage return.
  function automatic logic is_white(input logic [7:0] b);
    return (b == ASCII_SP) || (b == ASCII_TAB) ||
           (b == ASCII_LF) || (b == ASCII_CR);
  endfunction

endpackage

// File: rtl/sniffer_char_classifier.sv
// Combinational byte classifier shared by the sniffer blocks.
// Ports:
//   data       - byte to classify
//   num_flag   - byte is an ASCII decimal digit
//   white_flag - byte is space, tab, LF or CR
// A byte that is neither yields both flags low.
module sniffer_char_classifier
  import sniffer_pkg::*;
(
  input  logic [7:0] data,
  output logic       num_flag,
  output logic       white_flag
);

  assign num_flag   = is_digit(data);
  assign white_flag = is_white(data);

endmodule

// File: rtl/sniffer_shift_ctrl.sv
// Sequencer for the byte shift-register chain of the data sniffer.
// Accepts bytes over a valid/ready handshake, drives the chain's shared
// enable/data/flag inputs, tracks how many valid bytes the chain holds and
// reports each completed run of decimal digits. A flush pushes DEPTH
// whitespace bytes through the chain to empty it.
// Ports:
//   clk, rst        - clock (rising edge), asynchronous active-high reset
//   in_data/in_valid/in_ready - byte input handshake
//   flush_req       - level request for a flush, sampled in IDLE
//   sr_en, sr_data, sr_is_number, sr_is_white - chain head drive
//   fill_count      - valid bytes in the chain, saturating at DEPTH
//   num_found, num_len, num_overflow - one-cycle digit-run report
//   busy            - controller is not idle
module sniffer_shift_ctrl
  import sniffer_pkg::*;
#(
  parameter int          DEPTH      = 8,
  parameter logic [7:0]  FLUSH_CHAR = 8'h20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         flush_req,
  output logic                         sr_en,
  output logic [7:0]                   sr_data,
  output logic                         sr_is_number,
  output logic                         sr_is_white,
  output logic [$clog2(DEPTH+1)-1:0]   fill_count,
  output logic                         num_found,
  output logic [$clog2(DEPTH+1)-1:0]   num_len,
  output logic                         num_overflow,
  output logic                         busy
);

  localparam int FILL_W = $clog2(DEPTH + 1);
  // One extra code above DEPTH marks a run that overflowed the chain.
  localparam int RUN_W  = $clog2(DEPTH + 2);

  state_e              state_r;
  state_e              next_state_s;
  logic [FILL_W-1:0]   flush_cnt_r;
  logic [RUN_W-1:0]    run_len_r;
  logic                in_is_num_s;
  logic                in_is_white_s;
  logic                accept_s;

  sniffer_char_classifier u_classifier (
    .data       (in_data),
    .num_flag   (in_is_num_s),
    .white_flag (in_is_white_s)
  );

  // Flush takes priority over data: a pending flush blocks acceptance.
  assign in_ready = (state_r == IDLE) && !flush_req;
  assign accept_s = in_valid && in_ready;
  assign busy     = (state_r != IDLE);

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = SHIFT;
        end else if (flush_req) begin
          next_state_s = FLUSH;
        end else begin
          next_state_s = IDLE;
        end
      end
      SHIFT: next_state_s = IDLE;
      FLUSH: begin
        // Counter holds the enable cycles still to go, including this one.
        if (flush_cnt_r <= FILL_W'(1)) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = FLUSH;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, flush counter and chain-head drive registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      flush_cnt_r  <= {FILL_W{1'b0}};
      sr_en        <= 1'b0;
      sr_data      <= 8'h00;
      sr_is_number <= 1'b0;
      sr_is_white  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      // Enable is high in every non-idle cycle: one SHIFT or DEPTH FLUSH cycles.
      sr_en   <= (next_state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            sr_data      <= in_data;
            sr_is_number <= in_is_num_s;
            sr_is_white  <= in_is_white_s;
          end else if (flush_req) begin
            sr_data      <= FLUSH_CHAR;
            sr_is_number <= 1'b0;
            sr_is_white  <= 1'b1;
            flush_cnt_r  <= FILL_W'(DEPTH);
          end
        end
        FLUSH: begin
          flush_cnt_r <= flush_cnt_r - FILL_W'(1);
        end
        default: begin
          flush_cnt_r <= flush_cnt_r;
        end
      endcase
    end
  end

  // Chain fill tracking: count shifts, clear once a flush has emptied it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_count <= {FILL_W{1'b0}};
    end else if (state_r == SHIFT) begin
      if (fill_count < FILL_W'(DEPTH)) begin
        fill_count <= fill_count + FILL_W'(1);
      end
    end else if ((state_r == FLUSH) && (next_state_s == IDLE)) begin
      fill_count <= {FILL_W{1'b0}};
    end
  end

  // Digit-run tracking on every byte entering the chain; a non-digit
  // closes an open run and reports it in the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_len_r    <= {RUN_W{1'b0}};
      num_found    <= 1'b0;
      num_len      <= {FILL_W{1'b0}};
      num_overflow <= 1'b0;
    end else if (sr_en) begin
      if (sr_is_number) begin
        num_found <= 1'b0;
        if (run_len_r <= RUN_W'(DEPTH)) begin
          run_len_r <= run_len_r + RUN_W'(1);
        end
      end else if (run_len_r != {RUN_W{1'b0}}) begin
        num_found    <= 1'b1;
        num_overflow <= (run_len_r > RUN_W'(DEPTH));
        if (run_len_r > RUN_W'(DEPTH)) begin
          num_len <= FILL_W'(DEPTH);
        end else begin
          num_len <= run_len_r[FILL_W-1:0];
        end
        run_len_r <= {RUN_W{1'b0}};
      end else begin
        num_found <= 1'b0;
      end
    end else begin
      num_found <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sniffer_shift_ctrl.sv
// Directed testbench for sniffer_shift_ctrl (DEPTH=8, FLUSH_CHAR=0x20).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sniffer_shift_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       flush_req;
  logic       sr_en;
  logic [7:0] sr_data;
  logic       sr_is_number;
  logic       sr_is_white;
  logic [3:0] fill_count;
  logic       num_found;
  logic [3:0] num_len;
  logic       num_overflow;
  logic       busy;

  int n_total;
  int n_bad;

  sniffer_shift_ctrl #(.DEPTH(8), .FLUSH_CHAR(8'h20)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .flush_req    (flush_req),
    .sr_en        (sr_en),
    .sr_data      (sr_data),
    .sr_is_number (sr_is_number),
    .sr_is_white  (sr_is_white),
    .fill_count   (fill_count),
    .num_found    (num_found),
    .num_len      (num_len),
    .num_overflow (num_overflow),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Send one byte starting at an IDLE falling edge; returns at the next IDLE
  // falling edge with in_valid still high (caller drops it or sends again).
  task automatic send(input logic [7:0] b, input logic e_num, input logic e_white,
                      input int e_fill, input logic e_found, input int e_len,
                      input logic e_ovf);
    in_data  = b;
    in_valid = 1'b1;
    #1;
    chk("rdy_idle", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("rdy_shift", 32'(in_ready), 32'd0);
    chk("en_shift", 32'(sr_en), 32'd1);
    chk("sr_data", 32'(sr_data), 32'(b));
    chk("is_num", 32'(sr_is_number), 32'(e_num));
    chk("is_white", 32'(sr_is_white), 32'(e_white));
    @(negedge clk);
    chk("en_idle", 32'(sr_en), 32'd0);
    chk("fill", 32'(fill_count), 32'(e_fill));
    chk("found", 32'(num_found), 32'(e_found));
    if (e_found) begin
      chk("len", 32'(num_len), 32'(e_len));
      chk("ovf", 32'(num_overflow), 32'(e_ovf));
    end
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    rst       = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    flush_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_en", 32'(sr_en), 32'd0);
    chk("rst_data", 32'(sr_data), 32'd0);
    chk("rst_fill", 32'(fill_count), 32'd0);
    chk("rst_found", 32'(num_found), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // "12 " with valid held high between bytes
    send(8'h31, 1'b1, 1'b0, 1, 1'b0, 0, 1'b0);
    send(8'h32, 1'b1, 1'b0, 2, 1'b0, 0, 1'b0);
    send(8'h20, 1'b0, 1'b1, 3, 1'b1, 2, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_pulse_end", 32'(num_found), 32'd0);

    // ten digits then 'a': run overflows, fill saturates
    for (int i = 0; i < 10; i++) begin
      send(8'(8'h30 + i), 1'b1, 1'b0, ((4 + i) > 8) ? 8 : (4 + i), 1'b0, 0, 1'b0);
    end
    send(8'h61, 1'b0, 1'b0, 8, 1'b1, 8, 1'b1);
    in_valid = 1'b0;

    // "7" then flush
    send(8'h37, 1'b1, 1'b0, 8, 1'b0, 0, 1'b0);
    in_valid  = 1'b0;
    flush_req = 1'b1;
    #1;
    chk("t3_rdy", 32'(in_ready), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      flush_req = 1'b0;
      chk("t3_en", 32'(sr_en), 32'd1);
      chk("t3_data", 32'(sr_data), 32'h20);
      chk("t3_white", 32'(sr_is_white), 32'd1);
      chk("t3_found", 32'(num_found), (i == 1) ? 32'd1 : 32'd0);
      if (i == 1) chk("t3_len", 32'(num_len), 32'd1);
      if (i == 0) chk("t3_fill_hold", 32'(fill_count), 32'd8);
    end
    @(negedge clk);
    chk("t3_en_off", 32'(sr_en), 32'd0);
    chk("t3_fill", 32'(fill_count), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);

    // flush and valid together: flush wins, byte waits
    flush_req = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h35;
    #1;
    chk("t4_rdy", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush_req = 1'b0;
    chk("t4_busy", 32'(busy), 32'd1);
    chk("t4_data", 32'(sr_data), 32'h20);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk("t4_en", 32'(sr_en), 32'd1);
    end
    @(negedge clk);
    chk("t4_rdy_after", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("t4_accept_en", 32'(sr_en), 32'd1);
    chk("t4_accept_data", 32'(sr_data), 32'h35);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4_fill", 32'(fill_count), 32'd1);

    // reset in the third flush cycle
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    chk("t5_en1", 32'(sr_en), 32'd1);
    @(negedge clk);
    chk("t5_found", 32'(num_found), 32'd1);
    @(negedge clk);
    chk("t5_en3", 32'(sr_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_en", 32'(sr_en), 32'd0);
    chk("t5_rst_data", 32'(sr_data), 32'd0);
    chk("t5_rst_white", 32'(sr_is_white), 32'd0);
    chk("t5_rst_fill", 32'(fill_count), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t5_rst_hold_en", 32'(sr_en), 32'd0);
    rst = 1'b0;

    // "a\t5\r" accepted from the first idle cycle after reset
    send(8'h61, 1'b0, 1'b0, 1, 1'b0, 0, 1'b0);
    send(8'h09, 1'b0, 1'b1, 2, 1'b0, 0, 1'b0);
    send(8'h35, 1'b1, 1'b0, 3, 1'b0, 0, 1'b0);
    send(8'h0D, 1'b0, 1'b1, 4, 1'b1, 1, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_pulse_end", 32'(num_found), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sniffer_shift_ctrl.md
Name: sniffer_shift_ctrl

Overview:
- Sequences the byte shift-register chain of the data sniffer.
- Accepts a byte stream over a valid/ready handshake and classifies each byte as digit or whitespace.
- Drives the chain's shared enable, data and flag inputs, tracks chain fill, and detects completed decimal-number tokens.
- Provides a flush sequence that pushes whitespace through the chain to empty it.

Parameters:
DEPTH, 8, number of shift-register elements in the chain (>=2).
FLUSH_CHAR, 8'h20, byte shifted in during flush (must classify as whitespace).

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
in_data  in  8  incoming byte
in_valid  in  1  in_data valid
in_ready  out  1  controller accepts byte this cycle
flush_req  in  1  request to flush chain (level, sampled in IDLE)
sr_en  out  1  shift enable to every chain element
sr_data  out  8  byte into chain head
sr_is_number  out  1  head byte is ASCII digit
sr_is_white  out  1  head byte is whitespace
fill_count  out  $clog2(DEPTH+1)  valid bytes held in chain, saturating at DEPTH
num_found  out  1  one-cycle pulse: digit run just terminated
num_len  out  $clog2(DEPTH+1)  length of terminated run, valid with num_found
num_overflow  out  1  terminated run was longer than DEPTH, valid with num_found
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - sr_en, sr_data, sr_is_number, sr_is_white, fill_count, num_found, num_len, num_overflow all 0.
  - Internal run_len=0, flush counter=0.
  - Chain elements are not reset; fill_count=0 marks their contents invalid.
- Classification:
  - Digit = 8'h30..8'h39.
  - Whitespace = 8'h20, 8'h09, 8'h0A, 8'h0D.
  - All other bytes: both flags 0.
- in_ready = (state==IDLE) && !flush_req, combinational. Flush has priority over data.
- FSM:
  - IDLE:
    - Handshake (in_valid && in_ready) at edge N: register in_data and its flags onto sr_*, state->SHIFT.
    - Else if flush_req: load flush counter=DEPTH, state->FLUSH.
  - SHIFT (exactly one cycle): sr_en=1, so the chain captures at edge N+1; state->IDLE. Maximum throughput is therefore one byte per 2 cycles.
  - FLUSH: sr_en=1 each cycle with sr_data=FLUSH_CHAR, sr_is_white=1, sr_is_number=0. Counter decrements per cycle. State->IDLE on the cycle counter reaches 0, giving exactly DEPTH enable cycles. fill_count=0 on exit.
- sr_en is registered: high only in SHIFT, or for DEPTH cycles in FLUSH. sr_* hold their last value otherwise.
- fill_count:
  - +1 on each SHIFT cycle, saturating at DEPTH.
  - Unchanged during FLUSH; cleared on FLUSH->IDLE.
- Run tracking, evaluated on every byte entering the chain (SHIFT or FLUSH enable cycle):
  - Digit: run_len+1, saturating at DEPTH+1.
  - Non-digit with run_len>0: num_found=1 for the cycle after the enable.
    - num_len = min(run_len, DEPTH).
    - num_overflow = (run_len > DEPTH).
    - run_len->0.
  - Non-digit with run_len==0: no pulse.
- The first flush byte terminates any pending run, giving exactly one num_found pulse per flush at most.
- Width rule: run_len is $clog2(DEPTH+2) bits.
- Simultaneous flush_req and in_valid in IDLE: flush wins, byte not accepted.
- flush_req in SHIFT/FLUSH is ignored. A held request re-triggers a flush after returning to IDLE.
- Reset mid-SHIFT or mid-FLUSH: immediate return to reset values, partial flush abandoned, no num_found.

Decomposition:
- Package sniffer_pkg holds:
  - ASCII constants (ASCII_0, ASCII_9, ASCII_SP, ASCII_TAB, ASCII_LF, ASCII_CR).
  - State enum typedef {IDLE, SHIFT, FLUSH}.
  - Functions is_digit(byte), is_white(byte).
- One natural sub-module: sniffer_char_classifier (combinational byte -> is_number, is_white), reusable by other sniffer blocks.

Test Plan:
1. Reset then send "12 " (0x31,0x32,0x20) with in_valid held high:
   - in_ready toggles 1/0.
   - sr_en pulses 3 times, 2 cycles apart.
   - fill_count 1,2,3.
   - num_found once, after the 0x20 enable, with num_len=2, num_overflow=0.
2. DEPTH=8, send 10 digits then 'a' (0x61): num_found with num_len=8, num_overflow=1; fill_count saturates at 8.
3. Send "7", then assert flush_req:
   - Exactly 8 consecutive sr_en cycles with sr_data=0x20.
   - num_found (num_len=1) after the first flush shift.
   - fill_count=0 and busy=0 afterwards.
4. flush_req and in_valid asserted in the same IDLE cycle: in_ready=0, FSM enters FLUSH, byte is not consumed and is accepted after the flush completes.
5. Assert rst in the 3rd FLUSH cycle: all outputs 0 immediately (async), no further sr_en; after release, a new byte is accepted in the first IDLE cycle.
6. Send "a\t5\r": sr_is_white=1 for 0x09 and 0x0D, sr_is_number=1 for 0x35 only; num_found once with num_len=1 on 0x0D.
